// File: rtl/booth_seq_ctrl.sv
// Control FSM for a radix-2 Booth sequential multiplier.
// Sequences load, add/sub and arithmetic-shift strobes for an external datapath
// (accumulator, multiplier shift register, Q(-1) flop) and reports busy/done.
module booth_seq_ctrl #(
  parameter int N     = 4,  // operand width = number of Booth iterations (N >= 2)
  parameter int CNT_W = 3   // iteration counter width, 2**CNT_W > N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             q0,
  input  logic             q_m1,
  output logic             load_o,
  output logic             clr_acc_o,
  output logic             add_o,
  output logic             sub_o,
  output logic             shift_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EVAL  = 3'd2,
    S_ADD   = 3'd3,
    S_SUB   = 3'd4,
    S_SHIFT = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // State and iteration counter registers; rst clears both asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      iter_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_nxt;
      iter_cnt <= cnt_nxt;
    end
  end

  // Next-state and next-count logic; abort overrides every transition.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_nxt = state;
    cnt_nxt   = iter_cnt;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        cnt_nxt   = CNT_W'(N);
        state_nxt = S_EVAL;
      end
      S_EVAL: begin
        // Booth recoding: 01 adds the multiplicand, 10 subtracts it,
        // 00/11 go straight to the shift.
        unique case ({q0, q_m1})
          2'b01:   state_nxt = S_ADD;
          2'b10:   state_nxt = S_SUB;
          default: state_nxt = S_SHIFT;
        endcase
      end
      S_ADD:   state_nxt = S_SHIFT;
      S_SUB:   state_nxt = S_SHIFT;
      S_SHIFT: begin
        // The last shift always leaves for DONE, so the counter never wraps.
        cnt_nxt   = iter_cnt - CNT_W'(1);
        state_nxt = (iter_cnt == CNT_W'(1)) ? S_DONE : S_EVAL;
      end
      S_DONE: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end
  end

  // Moore output decode from the registered state only.
  always_comb begin
    load_o    = 1'b0;
    clr_acc_o = 1'b0;
    add_o     = 1'b0;
    sub_o     = 1'b0;
    shift_o   = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    unique case (state)
      S_LOAD: begin
        load_o    = 1'b1;
        clr_acc_o = 1'b1;
      end
      S_ADD:   add_o   = 1'b1;
      S_SUB:   sub_o   = 1'b1;
      S_SHIFT: shift_o = 1'b1;
      S_DONE:  done    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl. A tiny multiplier-register model
// feeds q0/q_m1 back; inputs are driven and outputs sampled on falling edges.
module tb_booth_seq_ctrl;

  localparam int N     = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic             q0;
  logic             q_m1;
  logic             load_o;
  logic             clr_acc_o;
  logic             add_o;
  logic             sub_o;
  logic             shift_o;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] iter_cnt;

  int total = 0;
  int bad   = 0;

  booth_seq_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .q0        (q0),
    .q_m1      (q_m1),
    .load_o    (load_o),
    .clr_acc_o (clr_acc_o),
    .add_o     (add_o),
    .sub_o     (sub_o),
    .shift_o   (shift_o),
    .busy      (busy),
    .done      (done),
    .iter_cnt  (iter_cnt)
  );

  always #5 clk = ~clk;

  // Multiplier shift register and Q(-1) model driven by the controller strobes.
  logic [3:0] mplier;
  logic [3:0] q_reg;
  logic       qm1_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg   <= '0;
      qm1_reg <= 1'b0;
    end else if (load_o) begin
      q_reg   <= mplier;
      qm1_reg <= 1'b0;
    end else if (shift_o) begin
      qm1_reg <= q_reg[0];
      q_reg   <= {q_reg[3], q_reg[3:1]};
    end
  end

  assign q0   = q_reg[0];
  assign q_m1 = qm1_reg;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Per-cycle strobe sanity: at most one datapath strobe, clear only with load.
  task automatic check_excl();
    int n;
    n = int'(load_o) + int'(add_o) + int'(sub_o) + int'(shift_o);
    check("one_strobe", (n <= 1) ? 1 : 0, 1);
    check("clr_with_load", int'(clr_acc_o & ~load_o), 0);
  endtask

  // Expected cycle count and add/sub count from the Booth pairs of m.
  function automatic int exp_cycles(input logic [3:0] m, output int nadd, output int nsub);
    int   c;
    logic prev;
    c = 2; prev = 1'b0; nadd = 0; nsub = 0;
    for (int i = 0; i < 4; i++) begin
      if (m[i] != prev) c += 3; else c += 2;
      if (m[i] && !prev) nsub++;
      if (!m[i] && prev) nadd++;
      prev = m[i];
    end
    return c;
  endfunction

  // Single start pulse, then run to the done cycle; returns on that cycle's falling edge.
  task automatic run_mult(input logic [3:0] m, output int cyc, output int nadd,
                          output int nsub, output int nshift, output int ndone);
    bit got;
    mplier = m;
    cyc = 0; nadd = 0; nsub = 0; nshift = 0; ndone = 0; got = 0;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk); start = 1'b0;
      check_excl();
      nadd   += int'(add_o);
      nsub   += int'(sub_o);
      nshift += int'(shift_o);
      if (done) begin
        cyc = k; ndone++; got = 1;
      end
    end
    if (!got) check("run_timeout", 0, 1);
  endtask

  typedef struct {
    logic [3:0] m;
    int         cyc;
    int         nadd;
    int         nsub;
  } vec_t;

  vec_t  vecs[6];
  string exp_seq;
  int    exp_cnt[12];

  function automatic byte strobe_code();
    if (load_o)  return "L";
    if (add_o)   return "A";
    if (sub_o)   return "B";
    if (shift_o) return "S";
    if (done)    return "D";
    if (busy)    return "E";
    return "I";
  endfunction

  initial begin
    int  cyc, nadd, nsub, nshift, ndone, ecyc, eadd, esub;
    bit  found;
    logic [3:0] rm;

    vecs[0] = '{m: 4'b0010, cyc: 12, nadd: 1, nsub: 1};
    vecs[1] = '{m: 4'b0000, cyc: 10, nadd: 0, nsub: 0};
    vecs[2] = '{m: 4'b0101, cyc: 14, nadd: 2, nsub: 2};
    vecs[3] = '{m: 4'b1111, cyc: 11, nadd: 0, nsub: 1};
    vecs[4] = '{m: 4'b1000, cyc: 11, nadd: 0, nsub: 1};
    vecs[5] = '{m: 4'b0110, cyc: 12, nadd: 1, nsub: 1};
    exp_seq = "LESEBSEASESD";
    exp_cnt = '{0, 4, 4, 3, 3, 3, 2, 2, 2, 1, 1, 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; mplier = '0;
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_iter_cnt", int'(iter_cnt), 0);
    check("rst_strobes", int'(load_o | clr_acc_o | add_o | sub_o | shift_o), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // Table-driven runs: latency, strobe counts, single done pulse.
    foreach (vecs[i]) begin
      run_mult(vecs[i].m, cyc, nadd, nsub, nshift, ndone);
      check($sformatf("cycles_m%b", vecs[i].m), cyc, vecs[i].cyc);
      check($sformatf("adds_m%b", vecs[i].m), nadd, vecs[i].nadd);
      check($sformatf("subs_m%b", vecs[i].m), nsub, vecs[i].nsub);
      check($sformatf("shifts_m%b", vecs[i].m), nshift, N);
      check($sformatf("done_cnt_m%b", vecs[i].m), int'(iter_cnt), 0);
      @(negedge clk);
      check($sformatf("post_done_m%b", vecs[i].m), int'(done | busy), 0);
    end

    // Cycle-exact trace for multiplier 0010.
    mplier = 4'b0010;
    @(negedge clk); start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); start = 1'b0;
      check($sformatf("trace_state_c%0d", k + 1), int'(strobe_code()), int'(exp_seq[k]));
      check($sformatf("trace_cnt_c%0d", k + 1), int'(iter_cnt), exp_cnt[k]);
    end
    @(negedge clk);
    check("trace_back_idle", int'(busy), 0);

    // Random multipliers against the pair-count model.
    for (int r = 0; r < 8; r++) begin
      rm   = 4'($urandom_range(0, 15));
      ecyc = exp_cycles(rm, eadd, esub);
      run_mult(rm, cyc, nadd, nsub, nshift, ndone);
      check($sformatf("rand_cycles_m%b", rm), cyc, ecyc);
      check($sformatf("rand_adds_m%b", rm), nadd, eadd);
      check($sformatf("rand_subs_m%b", rm), nsub, esub);
      @(negedge clk);
    end

    // Asynchronous reset during ADD.
    mplier = 4'b0010; found = 0;
    @(negedge clk); start = 1'b1;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk); start = 1'b0;
      if (add_o) found = 1;
    end
    check("rst_mid_reached_add", int'(found), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_add", int'(add_o), 0);
    check("rst_mid_iter_cnt", int'(iter_cnt), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("rst_mid_idle", int'(busy), 0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("rst_mid_load", int'(load_o), 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_from_load", int'(busy), 0);

    // start held high: one run, one-cycle done, one IDLE cycle, then LOAD.
    mplier = 4'b0000; found = 0; cyc = 0;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 40 && !found; k++) begin
      @(negedge clk);
      if (done) begin found = 1; cyc = k; end
    end
    check("held_done_cycle", cyc, 10);
    @(negedge clk);
    check("held_done_width", int'(done), 0);
    check("held_idle_gap", int'(busy), 0);
    @(negedge clk);
    check("held_reload", int'(load_o), 1);
    start = 1'b0; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("held_abort_idle", int'(busy), 0);

    // abort in the final SHIFT beats the SHIFT->DONE transition.
    mplier = 4'b0000; found = 0;
    @(negedge clk); start = 1'b1;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk); start = 1'b0;
      if (shift_o && iter_cnt == CNT_W'(1)) found = 1;
    end
    check("abort_reached_last_shift", int'(found), 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_shift", int'(shift_o), 0);
    check("abort_done", int'(done), 0);
    check("abort_iter_cnt", int'(iter_cnt), 0);
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ndone += int'(done);
    end
    check("abort_no_done_later", ndone, 0);

    // abort beats start in IDLE.
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("abort_vs_start_busy", int'(busy), 0);
    check("abort_vs_start_load", int'(load_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
